minmax_tracker4b: RTL and testbench
===================================

# minmax_tracker4b

Streaming 4-bit min/max tracker that sits directly downstream of the 4-bit comparator and consumes its ZF, SLTu and SLT flags. Accepts a frame of 4-bit samples over a valid/ready handshake and keeps a running minimum, maximum, sample count and an all-equal flag. Presents one result per frame on a valid/ready output port. Two comparator instances are used: sample vs. running min, and running max vs. sample.

## Interface
- CNT_W, default 8: width of the per-frame sample counter.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- mode_signed  input  1  1 = two's-complement ordering (SLT), 0 = unsigned ordering (SLTu); latched on the first sample of a frame.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  4  sample value.
- in_last  input  1  sample is the last of its frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_min  output  4  frame minimum.
- out_max  output  4  frame maximum.
- out_count  output  CNT_W  samples accepted in the frame.
- out_eq_all  output  1  every sample in the frame was equal.

## Operation
- Accept = in_valid & in_ready on a rising clk edge. Result handoff = out_valid & out_ready.
- FSM has three states:
  - IDLE: in_ready=1, out_valid=0. On accept: min=max=in_data, count=1, eq_all=1, mode latched. Next state is HOLD if in_last, else ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On accept:
    - min updates if the sample orders below min. Comparator A=in_data, B=min; use SLT or SLTu per the latched mode.
    - max updates if max orders below the sample. Comparator A=max, B=in_data; same flag selection.
    - eq_all clears if ZF from the sample-vs-min comparator is 0.
    - count increments.
    - in_last moves to HOLD. No accept means no change.
  - HOLD: in_ready=0, out_valid=1. Outputs are stable until handoff, then the FSM returns to IDLE.
- Equal values never update min or max.
- mode_signed changes mid-frame are ignored.
- in_data, in_last and mode_signed are don't-care when in_valid=0.
- out_min, out_max, out_count and out_eq_all are registered and hold their last values outside HOLD. Only out_valid qualifies them.

## Timing
- Reset values while rst=1 or immediately after reset: state IDLE, out_valid=0, out_min=0, out_max=0, out_count=0, out_eq_all=0, latched mode=0.
- in_ready reads 1 in IDLE, but no accept occurs while rst=1.
- Latency: out_valid rises on the clk edge that accepts the in_last sample, i.e. one cycle after the last accept.
- Throughput: one sample per cycle within a frame. Each frame then costs at least one HOLD cycle. A new frame's first sample can be accepted on the cycle after the handoff.
- in_ready and out_valid are decoded combinationally from state only. There are no combinational paths from in_valid or out_ready to outputs.
- Reset asserted mid-frame or in HOLD: the frame is abandoned at once and no result is produced.
- Count boundary at 2^CNT_W-1 accepted samples: behaviour is set by Configuration.

## Configuration
- MINMAX_TRACKER_SAT_EN defined: out_count saturates at 2^CNT_W-1. Further samples still update min, max and eq_all.
- MINMAX_TRACKER_SAT_EN undefined: out_count wraps modulo 2^CNT_W.

## Test plan
- Unsigned frame 7, E (last), mode_signed=0 -> out_min=7, out_max=E, out_count=2, out_eq_all=0; out_valid rises one cycle after the last accept.
- Same frame with mode_signed=1 -> out_min=E (-2), out_max=7.
- Frame 6, 6, 6 (last) -> min=max=6, count=3, out_eq_all=1. Then frame 3, 6, 3 (last) with out_ready held low 5 cycles:
  - in_ready=0 and outputs stable throughout the wait.
  - after handoff: min=3, max=6.
- Single-sample frame 5 with in_last -> IDLE to HOLD directly; min=max=5, count=1, eq_all=1.
- CNT_W=2, frame of 5 samples (last sample is the 5th) -> out_count=3 with MINMAX_TRACKER_SAT_EN defined, out_count=1 without.
- Assert rst after 2 accepted samples of a frame -> out_valid=0 and all outputs 0 on the next cycle. A following frame of 4 (last) reports min=max=4, count=1.

Source files
------------

// File: rtl/minmax_tracker4b.sv
// Streaming 4-bit min/max tracker: per-frame running min, max, sample count and all-equal flag.
// Optional MINMAX_TRACKER_SAT_EN makes the sample count saturate instead of wrapping.
module minmax_tracker4b #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_signed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_min,
  output logic [3:0]       out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_eq_all
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mode;
  logic [3:0]       r_min;
  logic [3:0]       r_max;
  logic [CNT_W-1:0] r_count;
  logic             r_eq_all;
  logic [3:0]       r_out_min;
  logic [3:0]       r_out_max;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_eq_all;

  logic             w_accept;
  logic             w_zf_min;
  logic             w_lt_min;
  logic             w_lt_max;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_min_nxt;
  logic [3:0]       w_max_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_eq_nxt;

  // Comparator "A orders below B": SLT for two's-complement, SLTu otherwise.
  function automatic logic lt4(input logic [3:0] a, input logic [3:0] b, input logic sgn);
    logic sltu;
    logic slt;
    sltu = (a < b);
    slt  = ($signed(a) < $signed(b));
    return sgn ? slt : sltu;
  endfunction

  assign w_accept = in_valid & in_ready;
  assign w_zf_min = (in_data == r_min);
  assign w_lt_min = lt4(in_data, r_min, r_mode);
  assign w_lt_max = lt4(r_max, in_data, r_mode);

`ifdef MINMAX_TRACKER_SAT_EN
  assign w_cnt_inc = (&r_count) ? r_count : r_count + CNT_W'(1);
`else
  assign w_cnt_inc = r_count + CNT_W'(1);
`endif

  always_comb begin
    w_min_nxt = r_min;
    w_max_nxt = r_max;
    w_cnt_nxt = r_count;
    w_eq_nxt  = r_eq_all;
    if (r_state == S_IDLE) begin
      w_min_nxt = in_data;
      w_max_nxt = in_data;
      w_cnt_nxt = CNT_W'(1);
      w_eq_nxt  = 1'b1;
    end else begin
      if (w_lt_min) w_min_nxt = in_data;
      if (w_lt_max) w_max_nxt = in_data;
      w_cnt_nxt = w_cnt_inc;
      w_eq_nxt  = r_eq_all & w_zf_min;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Handshake flags depend on state only, so no input-to-output combinational path exists.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = in_last ? S_HOLD : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= 1'b0;
      r_min        <= '0;
      r_max        <= '0;
      r_count      <= '0;
      r_eq_all     <= 1'b0;
      r_out_min    <= '0;
      r_out_max    <= '0;
      r_out_count  <= '0;
      r_out_eq_all <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) r_mode <= mode_signed;
      r_min    <= w_min_nxt;
      r_max    <= w_max_nxt;
      r_count  <= w_cnt_nxt;
      r_eq_all <= w_eq_nxt;
      if (in_last) begin
        r_out_min    <= w_min_nxt;
        r_out_max    <= w_max_nxt;
        r_out_count  <= w_cnt_nxt;
        r_out_eq_all <= w_eq_nxt;
      end
    end
  end

  assign out_min    = r_out_min;
  assign out_max    = r_out_max;
  assign out_count  = r_out_count;
  assign out_eq_all = r_out_eq_all;

endmodule

// File: tb/tb_minmax_tracker4b.sv
// Bench for minmax_tracker4b: two instances (CNT_W=8 and CNT_W=2) driven in lockstep,
// compared against a frame-level reference model.
module tb_minmax_tracker4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_signed;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_eq_all_a;
  logic [3:0] out_min_a, out_max_a;
  logic [7:0] out_count_a;
  logic       in_ready_b, out_valid_b, out_eq_all_b;
  logic [3:0] out_min_b, out_max_b;
  logic [1:0] out_count_b;

  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  minmax_tracker4b #(.CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .mode_signed(mode_signed), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_min(out_min_a),
    .out_max(out_max_a), .out_count(out_count_a), .out_eq_all(out_eq_all_a)
  );

  minmax_tracker4b #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .mode_signed(mode_signed), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_min(out_min_b),
    .out_max(out_max_b), .out_count(out_count_b), .out_eq_all(out_eq_all_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ord(input logic [3:0] v, input bit sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  function automatic int cnt_exp(input int n, input int w);
    int m;
    m = (1 << w) - 1;
`ifdef MINMAX_TRACKER_SAT_EN
    return (n > m) ? m : n;
`else
    return n & m;
`endif
  endfunction

  task automatic check_outs(input string tag, input logic [3:0] emin, input logic [3:0] emax,
                            input int n, input bit eq);
    check({tag, "_min_a"}, out_min_a, emin);
    check({tag, "_max_a"}, out_max_a, emax);
    check({tag, "_cnt_a"}, out_count_a, cnt_exp(n, 8));
    check({tag, "_eq_a"},  out_eq_all_a, eq);
    check({tag, "_min_b"}, out_min_b, emin);
    check({tag, "_max_b"}, out_max_b, emax);
    check({tag, "_cnt_b"}, out_count_b, cnt_exp(n, 2));
    check({tag, "_eq_b"},  out_eq_all_b, eq);
  endtask

  // Sends the samples in q as one frame, then holds out_ready low for 'hold' cycles before handoff.
  task automatic run_frame(input bit mode, input int hold, input bit gaps);
    logic [3:0] emin, emax;
    bit eq;
    int n;
    n = q.size();
    emin = q[0];
    emax = q[0];
    eq = 1'b1;
    foreach (q[i]) begin
      if (ord(q[i], mode) < ord(emin, mode)) emin = q[i];
      if (ord(q[i], mode) > ord(emax, mode)) emax = q[i];
      if (q[i] != q[0]) eq = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0; in_data = 4'($urandom); in_last = 1'($urandom);
          mode_signed = 1'($urandom);
        end
      end
      @(negedge clk);
      check("in_ready_a", in_ready_a, 1'b1);
      check("in_ready_b", in_ready_b, 1'b1);
      in_valid = 1'b1;
      in_data = q[i];
      in_last = (i == n - 1);
      mode_signed = (i == 0) ? mode : 1'($urandom);
      @(posedge clk); #1;
      check("out_valid_lat_a", out_valid_a, in_last);
      check("out_valid_lat_b", out_valid_b, in_last);
    end
    check_outs("hold0", emin, emax, n, eq);
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_data = 4'($urandom); in_last = 1'($urandom);
      mode_signed = 1'($urandom); out_ready = 1'b0;
      check("hold_in_ready", in_ready_a, 1'b0);
      @(posedge clk); #1;
      check("hold_valid", out_valid_a, 1'b1);
      check_outs("hold", emin, emax, n, eq);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_valid", out_valid_a, 1'b0);
    check("handoff_in_ready", in_ready_a, 1'b1);
    check_outs("after", emin, emax, n, eq);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode_signed = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    in_last = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_in_ready", in_ready_a, 1'b1);
    check_outs("rst", 4'h0, 4'h0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    q = '{4'h7, 4'hE};
    run_frame(1'b0, 0, 1'b0);
    check("t1_min", out_min_a, 4'h7);
    check("t1_max", out_max_a, 4'hE);
    run_frame(1'b1, 1, 1'b0);
    check("t2_min", out_min_a, 4'hE);
    check("t2_max", out_max_a, 4'h7);

    q = '{4'h6, 4'h6, 4'h6};
    run_frame(1'b0, 0, 1'b0);
    check("t3_eq", out_eq_all_a, 1'b1);
    q = '{4'h3, 4'h6, 4'h3};
    run_frame(1'b0, 5, 1'b0);
    check("t4_min", out_min_a, 4'h3);
    check("t4_max", out_max_a, 4'h6);

    q = '{4'h5};
    run_frame(1'b0, 2, 1'b0);
    check("t5_cnt", out_count_a, 8'd1);

    q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    run_frame(1'b0, 0, 1'b0);
`ifdef MINMAX_TRACKER_SAT_EN
    check("t6_cnt_b", out_count_b, 2'd3);
`else
    check("t6_cnt_b", out_count_b, 2'd1);
`endif

    // Abandon a frame after two accepts.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 4'h9 + 4'(i); in_last = 1'b0; mode_signed = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid_a, 1'b0);
    check_outs("rst_mid", 4'h0, 4'h0, 0, 1'b0);
    @(posedge clk); #1;
    check("rst_mid_valid2", out_valid_a, 1'b0);
    check("rst_mid_in_ready", in_ready_a, 1'b1);
    check_outs("rst_mid2", 4'h0, 4'h0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    q = '{4'h4};
    run_frame(1'b0, 0, 1'b0);
    check("t7_min", out_min_a, 4'h4);
    check("t7_cnt", out_count_a, 8'd1);

    q = {};
    for (int i = 0; i < 300; i++) q.push_back(4'($urandom));
    run_frame(1'($urandom), 1, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int len;
      bit eqf;
      len = $urandom_range(1, 10);
      eqf = ($urandom_range(0, 4) == 0);
      q = {};
      q.push_back(4'($urandom));
      for (int i = 1; i < len; i++) q.push_back(eqf ? q[0] : 4'($urandom));
      run_frame(1'($urandom), $urandom_range(0, 3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
